// File: rtl/mem_bus_unit.sv
// Memory stage: one 16-bit word request is carried out as two byte cycles on an
// 8-bit external bus, with wait states, ext_rdy stretching and a bus timeout.
module mem_bus_unit #(
    parameter int WAIT    = 1,
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rqm,
    input  logic        rwm,
    input  logic [19:0] adm,
    input  logic [15:0] dwm,
    output logic        akm,
    output logic [15:0] drm,
    output logic        err,
    output logic        busy,
    output logic [19:0] ext_adr,
    output logic [7:0]  ext_dout,
    input  logic [7:0]  ext_din,
    output logic        ext_oe,
    output logic        ext_we,
    input  logic        ext_rdy
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_LO,
        S_GAP,
        S_HI,
        S_ACK
    } state_t;

    localparam logic [3:0] WAIT_C    = 4'(WAIT);
    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    state_t      state_q, state_d;
    logic        wr_q, wr_d;
    logic [7:0]  hi_byte_q, hi_byte_d;
    logic [7:0]  rbuf_lo_q, rbuf_lo_d;
    logic [3:0]  wcnt_q, wcnt_d;
    logic [7:0]  tcnt_q, tcnt_d;
    logic        akm_q, akm_d;
    logic        err_q, err_d;
    logic        busy_q, busy_d;
    logic [15:0] drm_q, drm_d;
    logic [19:0] ext_adr_q, ext_adr_d;
    logic [7:0]  ext_dout_q, ext_dout_d;
    logic        ext_oe_q, ext_oe_d;
    logic        ext_we_q, ext_we_d;
    logic        phase_done, phase_abort;

    always_comb begin
        // NOTE: every _d gets a default before any branch, so no path can infer a latch.
        state_d     = state_q;
        wr_d        = wr_q;
        hi_byte_d   = hi_byte_q;
        rbuf_lo_d   = rbuf_lo_q;
        wcnt_d      = wcnt_q;
        tcnt_d      = tcnt_q;
        akm_d       = 1'b0;
        err_d       = 1'b0;
        drm_d       = drm_q;
        ext_adr_d   = ext_adr_q;
        ext_dout_d  = ext_dout_q;
        ext_oe_d    = ext_oe_q;
        ext_we_d    = ext_we_q;
        phase_done  = 1'b0;
        phase_abort = 1'b0;

        // ext_rdy only matters once the wait count has run out.
        if (state_q == S_LO || state_q == S_HI) begin
            if (wcnt_q != 4'd0) begin
                wcnt_d = wcnt_q - 4'd1;
            end else if (ext_rdy) begin
                phase_done = 1'b1;
            end else begin
                tcnt_d      = tcnt_q + 8'd1;
                phase_abort = (tcnt_d == TIMEOUT_C);
            end
        end

        unique case (state_q)
            S_IDLE: begin
                if (rqm) begin
                    state_d    = S_LO;
                    wr_d       = rwm;
                    hi_byte_d  = dwm[15:8];
                    ext_adr_d  = adm;
                    ext_dout_d = dwm[7:0];
                    ext_oe_d   = !rwm;
                    ext_we_d   = rwm;
                    wcnt_d     = WAIT_C;
                    tcnt_d     = 8'd0;
                end
            end
            S_LO, S_HI: begin
                if (phase_abort) begin
                    state_d  = S_ACK;
                    akm_d    = 1'b1;
                    err_d    = 1'b1;
                    ext_oe_d = 1'b0;
                    ext_we_d = 1'b0;
                    if (!wr_q) drm_d = 16'hFFFF;
                end else if (phase_done) begin
                    ext_oe_d = 1'b0;
                    ext_we_d = 1'b0;
                    if (state_q == S_LO) begin
                        state_d = S_GAP;
                        if (!wr_q) rbuf_lo_d = ext_din;
                    end else begin
                        state_d = S_ACK;
                        akm_d   = 1'b1;
                        if (!wr_q) drm_d = {ext_din, rbuf_lo_q};
                    end
                end
            end
            S_GAP: begin
                state_d    = S_HI;
                ext_adr_d  = ext_adr_q + 20'd1;
                ext_dout_d = hi_byte_q;
                ext_oe_d   = !wr_q;
                ext_we_d   = wr_q;
                wcnt_d     = WAIT_C;
                tcnt_d     = 8'd0;
            end
            S_ACK:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) begin
            state_q    <= S_IDLE;
            wr_q       <= 1'b0;
            hi_byte_q  <= 8'h00;
            rbuf_lo_q  <= 8'h00;
            wcnt_q     <= 4'd0;
            tcnt_q     <= 8'd0;
            akm_q      <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            drm_q      <= 16'h0000;
            ext_adr_q  <= 20'h00000;
            ext_dout_q <= 8'h00;
            ext_oe_q   <= 1'b0;
            ext_we_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_q       <= wr_d;
            hi_byte_q  <= hi_byte_d;
            rbuf_lo_q  <= rbuf_lo_d;
            wcnt_q     <= wcnt_d;
            tcnt_q     <= tcnt_d;
            akm_q      <= akm_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            drm_q      <= drm_d;
            ext_adr_q  <= ext_adr_d;
            ext_dout_q <= ext_dout_d;
            ext_oe_q   <= ext_oe_d;
            ext_we_q   <= ext_we_d;
        end
    end

    assign akm      = akm_q;
    assign err      = err_q;
    assign busy     = busy_q;
    assign drm      = drm_q;
    assign ext_adr  = ext_adr_q;
    assign ext_dout = ext_dout_q;
    assign ext_oe   = ext_oe_q;
    assign ext_we   = ext_we_q;

endmodule

// File: tb/tb_mem_bus_unit.sv
// Bench for mem_bus_unit: three instances (WAIT/TIMEOUT = 0/64, 2/64, 0/4) driven by
// directed and random transactions, checked against a phase-duration model.
module tb_mem_bus_unit;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        rqm      [3];
    logic        rwm      [3];
    logic [19:0] adm      [3];
    logic [15:0] dwm      [3];
    logic        akm      [3];
    logic [15:0] drm      [3];
    logic        err      [3];
    logic        busy     [3];
    logic [19:0] ext_adr  [3];
    logic [7:0]  ext_dout [3];
    logic [7:0]  ext_din  [3];
    logic        ext_oe   [3];
    logic        ext_we   [3];
    logic        ext_rdy  [3];

    mem_bus_unit #(.WAIT(0), .TIMEOUT(64)) u0 (
        .clk(clk), .rst(rst), .rqm(rqm[0]), .rwm(rwm[0]), .adm(adm[0]), .dwm(dwm[0]),
        .akm(akm[0]), .drm(drm[0]), .err(err[0]), .busy(busy[0]), .ext_adr(ext_adr[0]),
        .ext_dout(ext_dout[0]), .ext_din(ext_din[0]), .ext_oe(ext_oe[0]), .ext_we(ext_we[0]),
        .ext_rdy(ext_rdy[0]));
    mem_bus_unit #(.WAIT(2), .TIMEOUT(64)) u1 (
        .clk(clk), .rst(rst), .rqm(rqm[1]), .rwm(rwm[1]), .adm(adm[1]), .dwm(dwm[1]),
        .akm(akm[1]), .drm(drm[1]), .err(err[1]), .busy(busy[1]), .ext_adr(ext_adr[1]),
        .ext_dout(ext_dout[1]), .ext_din(ext_din[1]), .ext_oe(ext_oe[1]), .ext_we(ext_we[1]),
        .ext_rdy(ext_rdy[1]));
    mem_bus_unit #(.WAIT(0), .TIMEOUT(4)) u2 (
        .clk(clk), .rst(rst), .rqm(rqm[2]), .rwm(rwm[2]), .adm(adm[2]), .dwm(dwm[2]),
        .akm(akm[2]), .drm(drm[2]), .err(err[2]), .busy(busy[2]), .ext_adr(ext_adr[2]),
        .ext_dout(ext_dout[2]), .ext_din(ext_din[2]), .ext_oe(ext_oe[2]), .ext_we(ext_we[2]),
        .ext_rdy(ext_rdy[2]));

    function automatic int wait_of(input int s);
        return (s == 1) ? 2 : 0;
    endfunction

    function automatic int tmo_of(input int s);
        return (s == 2) ? 4 : 64;
    endfunction

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Device model: byte memory, ready after a programmed number of cycles per phase,
    // and a log of every strobed phase seen on the bus.
    typedef struct {
        int          cycles;
        logic [19:0] adr;
        logic [7:0]  dout;
        logic        oe;
        logic        we;
    } phase_rec_t;

    logic [7:0] mem [int];
    phase_rec_t log_q[$];
    int cur = 0;
    int stall_lo = 0;
    int stall_hi = 0;
    int dev_phase = 0;
    int both_hi = 0;
    logic [15:0] exp_drm [3];

    function automatic logic [7:0] mem_rd(input logic [19:0] a);
        if (mem.exists(int'(a))) return mem[int'(a)];
        return 8'h00;
    endfunction

    initial begin
        phase_rec_t rec;
        int pcnt;
        pcnt = 0;
        rec = '{cycles: 0, adr: '0, dout: '0, oe: 1'b0, we: 1'b0};
        for (int i = 0; i < 3; i++) begin
            ext_rdy[i] = 1'b0;
            ext_din[i] = 8'h00;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (ext_oe[i] === 1'b1 && ext_we[i] === 1'b1) both_hi++;
                if (i != cur) begin
                    ext_rdy[i] = 1'b0;
                    ext_din[i] = 8'h00;
                end
            end
            if (ext_oe[cur] === 1'b1 || ext_we[cur] === 1'b1) begin
                if (pcnt == 0) begin
                    dev_phase++;
                    rec.adr  = ext_adr[cur];
                    rec.dout = ext_dout[cur];
                    rec.oe   = ext_oe[cur];
                    rec.we   = ext_we[cur];
                end
                ext_rdy[cur] = (pcnt >= ((dev_phase == 1) ? stall_lo : stall_hi));
                ext_din[cur] = mem_rd(ext_adr[cur]);
                pcnt++;
            end else begin
                if (pcnt > 0) begin
                    rec.cycles = pcnt;
                    log_q.push_back(rec);
                    pcnt = 0;
                end
                ext_rdy[cur] = 1'b0;
            end
        end
    end

    // Cycles spent strobed in one phase whose ready comes l cycles after entry.
    function automatic int phase_len(input int w, input int t, input int l, output bit ab);
        ab = (l >= w + t);
        if (ab) return w + t;
        return ((w > l) ? w : l) + 1;
    endfunction

    task automatic run_txn(input int sel, input bit wr, input logic [19:0] a, input logic [15:0] d,
                           input int lo, input int hi, input bit keep);
        int w, t, dlo, dhi, k_exp, got_k, n_exp;
        bit ab_lo, ab_hi, exp_err;
        logic [19:0] a1;
        w  = wait_of(sel);
        t  = tmo_of(sel);
        a1 = a + 20'd1;
        dlo = phase_len(w, t, lo, ab_lo);
        dhi = phase_len(w, t, hi, ab_hi);
        if (ab_lo) begin
            exp_err = 1'b1; k_exp = dlo; n_exp = 1;
        end else begin
            exp_err = ab_hi; k_exp = dlo + 1 + dhi; n_exp = 2;
        end
        if (!wr) exp_drm[sel] = exp_err ? 16'hFFFF : {mem_rd(a1), mem_rd(a)};

        cur = sel; stall_lo = lo; stall_hi = hi; dev_phase = 0; log_q.delete();
        rqm[sel] = 1'b1; rwm[sel] = wr; adm[sel] = a; dwm[sel] = d;
        @(posedge clk);
        got_k = -1;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (k == 0) begin
                rwm[sel] = 1'($urandom);
                adm[sel] = 20'($urandom);
                dwm[sel] = 16'($urandom);
            end
            if (akm[sel] === 1'b1) begin
                got_k = k;
                break;
            end
            check("busy_in_txn", 32'(busy[sel]), 32'd1);
        end
        check("ack_latency", got_k, k_exp);
        if (got_k >= 0) begin
            check("ack_drm", 32'(drm[sel]), 32'(exp_drm[sel]));
            check("ack_err", 32'(err[sel]), 32'(exp_err));
        end
        if (!keep) rqm[sel] = 1'b0;
        @(negedge clk);
        check("akm_one_cycle", 32'(akm[sel]), 32'd0);
        check("busy_idle", 32'(busy[sel]), 32'd0);
        check("drm_hold", 32'(drm[sel]), 32'(exp_drm[sel]));
        check("phase_count", log_q.size(), n_exp);
        for (int i = 0; i < n_exp && i < log_q.size(); i++) begin
            check("phase_cycles", log_q[i].cycles, (i == 0) ? dlo : dhi);
            check("phase_adr", 32'(log_q[i].adr), 32'((i == 0) ? a : a1));
            check("phase_oe", 32'(log_q[i].oe), 32'(!wr));
            check("phase_we", 32'(log_q[i].we), 32'(wr));
            if (wr) check("phase_dout", 32'(log_q[i].dout), 32'((i == 0) ? d[7:0] : d[15:8]));
        end
    endtask

    task automatic check_reset_outputs(input int i);
        check("rst_akm", 32'(akm[i]), 32'd0);
        check("rst_err", 32'(err[i]), 32'd0);
        check("rst_busy", 32'(busy[i]), 32'd0);
        check("rst_drm", 32'(drm[i]), 32'd0);
        check("rst_ext_adr", 32'(ext_adr[i]), 32'd0);
        check("rst_ext_dout", 32'(ext_dout[i]), 32'd0);
        check("rst_ext_oe", 32'(ext_oe[i]), 32'd0);
        check("rst_ext_we", 32'(ext_we[i]), 32'd0);
    endtask

    task automatic rand_txn(input int sel, input bit keep);
        bit wr;
        logic [19:0] a;
        wr = 1'($urandom);
        a  = ($urandom_range(0, 7) == 0) ? 20'hFFFFF : 20'($urandom);
        if (!wr) begin
            mem[int'(a)]         = 8'($urandom);
            mem[int'(a + 20'd1)] = 8'($urandom);
        end
        run_txn(sel, wr, a, 16'($urandom), $urandom_range(0, 6), $urandom_range(0, 6), keep);
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rqm[i] = 1'b0; rwm[i] = 1'b0; adm[i] = '0; dwm[i] = '0; exp_drm[i] = '0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) check_reset_outputs(i);
        rst = 1'b0;
        @(negedge clk);

        // Read, WAIT=0, always ready.
        mem[32'h12340] = 8'hCD;
        mem[32'h12341] = 8'hAB;
        run_txn(0, 1'b0, 20'h12340, 16'h0000, 0, 0, 1'b0);
        check("read_abcd", 32'(drm[0]), 32'h0000ABCD);

        // Write with WAIT=2 at the top of the address space (wraps to 0).
        run_txn(1, 1'b1, 20'hFFFFF, 16'hBEEF, 0, 0, 1'b0);

        // Read stretched by ext_rdy low for 5 cycles in HI only.
        mem[32'h00420] = 8'h5A;
        mem[32'h00421] = 8'hC3;
        run_txn(0, 1'b0, 20'h00420, 16'h0000, 0, 5, 1'b0);

        // Read with ext_rdy stuck low on the TIMEOUT=4 instance.
        run_txn(2, 1'b0, 20'h00777, 16'h0000, 1000, 1000, 1'b0);

        // Reset while the HI phase of a write is on the bus.
        cur = 1; stall_lo = 0; stall_hi = 0; dev_phase = 0; log_q.delete();
        rqm[1] = 1'b1; rwm[1] = 1'b1; adm[1] = 20'h0ABCD; dwm[1] = 16'h1234;
        @(posedge clk);
        repeat (5) @(negedge clk);
        check("pre_rst_in_hi_we", 32'(ext_we[1]), 32'd1);
        check("pre_rst_in_hi_adr", 32'(ext_adr[1]), 32'h0ABCE);
        rst = 1'b1;
        rqm[1] = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check_reset_outputs(i);
            exp_drm[i] = '0;
        end
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("no_ack_after_rst", 32'(akm[1]), 32'd0);
        end
        run_txn(1, 1'b1, 20'h0ABCD, 16'h1234, 1, 0, 1'b0);

        // Back-to-back with rqm held high across the first acknowledge.
        mem[32'h00010] = 8'h11;
        mem[32'h00011] = 8'h22;
        run_txn(0, 1'b0, 20'h00010, 16'h0000, 0, 0, 1'b1);
        run_txn(0, 1'b1, 20'h00020, 16'h7788, 0, 0, 1'b0);

        for (int n = 0; n < 60; n++) begin
            int  sel;
            bit  pair;
            sel  = $urandom_range(0, 2);
            pair = ($urandom_range(0, 3) == 0);
            rand_txn(sel, pair);
            if (pair) rand_txn(sel, 1'b0);
        end

        check("never_both_strobes", both_hi, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
